// File: rtl/pipe_pkg.sv
// Shared MIPS pipeline definitions: opcode/funct constants, the NOP word,
// and the per-lane ID/EX payload record held by each pipeline lane.
package pipe_pkg;

    localparam logic [5:0]  SPECIAL = 6'b000000;
    localparam logic [5:0]  MOVZ    = 6'b001010;
    localparam logic [5:0]  MOVN    = 6'b001011;
    localparam logic [31:0] NOP     = 32'h0000_0000;

    // Storage width of the payload record; lanes narrower than this use the low bits.
    localparam int PAYLOAD_DW = 32;
    localparam int PAYLOAD_AW = 5;

    typedef struct packed {
        logic                  valid;
        logic [PAYLOAD_DW-1:0] ir;
        logic [PAYLOAD_DW-1:0] pc4;
        logic [PAYLOAD_DW-1:0] rs;
        logic [PAYLOAD_DW-1:0] rt;
        logic [PAYLOAD_DW-1:0] ext;
        logic [PAYLOAD_DW-1:0] wb_data;
        logic [PAYLOAD_AW-1:0] a3;
        logic                  reg_write;
        logic                  mem_write;
    } id_ex_payload_t;

    // True when the instruction word is a movz/movn.
    function automatic logic is_cmov(input logic [31:0] ir);
        return (ir[31:26] == SPECIAL) && ((ir[5:0] == MOVZ) || (ir[5:0] == MOVN));
    endfunction

endpackage

// File: rtl/id_ex_pipe_reg_if.sv
// ID->EX bundle: D-stage payload and stage controls in, EX-stage copies and
// statistics out. master = ID side, slave = the pipeline register.
interface id_ex_pipe_reg_if #(
    parameter int LANES = 1,
    parameter int DW    = 32,
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic                  hold_e;
    logic                  flush_e;
    logic [LANES*DW-1:0]   ir_d;
    logic [LANES*DW-1:0]   pc4_d;
    logic [LANES*DW-1:0]   pc8_d;
    logic [LANES*DW-1:0]   rs_d;
    logic [LANES*DW-1:0]   rt_d;
    logic [LANES*DW-1:0]   ext_d;
    logic [LANES*AW-1:0]   a3_d;
    logic [LANES-1:0]      reg_write_d;
    logic [LANES-1:0]      mem_write_d;
    logic [LANES-1:0]      cmov_d;
    logic [LANES-1:0]      cond_d;

    logic [LANES-1:0]      valid_e;
    logic [LANES*DW-1:0]   ir_e;
    logic [LANES*DW-1:0]   pc4_e;
    logic [LANES*DW-1:0]   rs_e;
    logic [LANES*DW-1:0]   rt_e;
    logic [LANES*DW-1:0]   ext_e;
    logic [LANES*DW-1:0]   wb_data_e;
    logic [LANES*AW-1:0]   a3_e;
    logic [LANES-1:0]      reg_write_e;
    logic [LANES-1:0]      mem_write_e;
    logic [CNT_W-1:0]      bubble_cnt;
    logic [CNT_W-1:0]      hold_cnt;

    modport master (
        output hold_e, flush_e, ir_d, pc4_d, pc8_d, rs_d, rt_d, ext_d, a3_d,
               reg_write_d, mem_write_d, cmov_d, cond_d,
        input  valid_e, ir_e, pc4_e, rs_e, rt_e, ext_e, wb_data_e, a3_e,
               reg_write_e, mem_write_e, bubble_cnt, hold_cnt
    );

    modport slave (
        input  hold_e, flush_e, ir_d, pc4_d, pc8_d, rs_d, rt_d, ext_d, a3_d,
               reg_write_d, mem_write_d, cmov_d, cond_d,
        output valid_e, ir_e, pc4_e, rs_e, rt_e, ext_e, wb_data_e, a3_e,
               reg_write_e, mem_write_e, bubble_cnt, hold_cnt
    );
endinterface

// File: rtl/id_ex_lane.sv
// One ID->EX issue slot: flush beats hold beats load. A not-taken conditional
// move stays a valid instruction but loses its register write.
module id_ex_lane
    import pipe_pkg::*;
#(
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter bit CMOV_EN = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          hold_i,
    input  logic          flush_i,
    input  logic [DW-1:0] ir_i,
    input  logic [DW-1:0] pc4_i,
    input  logic [DW-1:0] pc8_i,
    input  logic [DW-1:0] rs_i,
    input  logic [DW-1:0] rt_i,
    input  logic [DW-1:0] ext_i,
    input  logic [AW-1:0] a3_i,
    input  logic          reg_write_i,
    input  logic          mem_write_i,
    input  logic          cmov_i,
    input  logic          cond_i,
    output logic          valid_o,
    output logic [DW-1:0] ir_o,
    output logic [DW-1:0] pc4_o,
    output logic [DW-1:0] rs_o,
    output logic [DW-1:0] rt_o,
    output logic [DW-1:0] ext_o,
    output logic [DW-1:0] wb_data_o,
    output logic [AW-1:0] a3_o,
    output logic          reg_write_o,
    output logic          mem_write_o
);

    id_ex_payload_t payload_d;
    id_ex_payload_t payload_q;
    logic           cmov_take;
    logic           cmov_kill;

    // Next lane contents: bubble, frozen copy, or freshly decoded instruction.
    always_comb begin
        cmov_take = CMOV_EN && cmov_i && cond_i;
        cmov_kill = CMOV_EN && cmov_i && !cond_i;
        payload_d = payload_q;
        if (flush_i) begin
            payload_d    = '0;
            payload_d.ir = NOP;
        end else if (hold_i) begin
            payload_d = payload_q;
        end else begin
            payload_d.valid     = 1'b1;
            payload_d.ir        = PAYLOAD_DW'(ir_i);
            payload_d.pc4       = PAYLOAD_DW'(pc4_i);
            payload_d.rs        = PAYLOAD_DW'(rs_i);
            payload_d.rt        = PAYLOAD_DW'(rt_i);
            payload_d.ext       = PAYLOAD_DW'(ext_i);
            payload_d.wb_data   = cmov_take ? PAYLOAD_DW'(rs_i) : PAYLOAD_DW'(pc8_i);
            payload_d.a3        = cmov_kill ? '0 : PAYLOAD_AW'(a3_i);
            payload_d.reg_write = cmov_kill ? 1'b0 : reg_write_i;
            payload_d.mem_write = mem_write_i;
        end
    end

    // Lane register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            payload_q <= '0;
        end else begin
            payload_q <= payload_d;
        end
    end

    assign valid_o     = payload_q.valid;
    assign ir_o        = payload_q.ir[DW-1:0];
    assign pc4_o       = payload_q.pc4[DW-1:0];
    assign rs_o        = payload_q.rs[DW-1:0];
    assign rt_o        = payload_q.rt[DW-1:0];
    assign ext_o       = payload_q.ext[DW-1:0];
    assign wb_data_o   = payload_q.wb_data[DW-1:0];
    assign a3_o        = payload_q.a3[AW-1:0];
    assign reg_write_o = payload_q.reg_write;
    assign mem_write_o = payload_q.mem_write;

endmodule

// File: rtl/id_ex_pipe_reg.sv
// ID->EX pipeline register, LANES issue slots wide, with saturating
// bubble/hold statistics for the perf/debug readout.
module id_ex_pipe_reg
    import pipe_pkg::*;
#(
    parameter int LANES   = 1,
    parameter int DW      = 32,
    parameter int AW      = 5,
    parameter bit CMOV_EN = 1'b1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              reset,
    id_ex_pipe_reg_if.slave   bus
);

    logic [LANES-1:0]    valid_s;
    logic [LANES*DW-1:0] ir_s;
    logic [LANES*DW-1:0] pc4_s;
    logic [LANES*DW-1:0] rs_s;
    logic [LANES*DW-1:0] rt_s;
    logic [LANES*DW-1:0] ext_s;
    logic [LANES*DW-1:0] wb_data_s;
    logic [LANES*AW-1:0] a3_s;
    logic [LANES-1:0]    reg_write_s;
    logic [LANES-1:0]    mem_write_s;
    logic [CNT_W-1:0]    bubble_cnt_d;
    logic [CNT_W-1:0]    bubble_cnt_q;
    logic [CNT_W-1:0]    hold_cnt_d;
    logic [CNT_W-1:0]    hold_cnt_q;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        id_ex_lane #(.DW(DW), .AW(AW), .CMOV_EN(CMOV_EN)) u_lane (
            .clk         (clk),
            .reset       (reset),
            .hold_i      (bus.hold_e),
            .flush_i     (bus.flush_e),
            .ir_i        (bus.ir_d[g*DW +: DW]),
            .pc4_i       (bus.pc4_d[g*DW +: DW]),
            .pc8_i       (bus.pc8_d[g*DW +: DW]),
            .rs_i        (bus.rs_d[g*DW +: DW]),
            .rt_i        (bus.rt_d[g*DW +: DW]),
            .ext_i       (bus.ext_d[g*DW +: DW]),
            .a3_i        (bus.a3_d[g*AW +: AW]),
            .reg_write_i (bus.reg_write_d[g]),
            .mem_write_i (bus.mem_write_d[g]),
            .cmov_i      (bus.cmov_d[g]),
            .cond_i      (bus.cond_d[g]),
            .valid_o     (valid_s[g]),
            .ir_o        (ir_s[g*DW +: DW]),
            .pc4_o       (pc4_s[g*DW +: DW]),
            .rs_o        (rs_s[g*DW +: DW]),
            .rt_o        (rt_s[g*DW +: DW]),
            .ext_o       (ext_s[g*DW +: DW]),
            .wb_data_o   (wb_data_s[g*DW +: DW]),
            .a3_o        (a3_s[g*AW +: AW]),
            .reg_write_o (reg_write_s[g]),
            .mem_write_o (mem_write_s[g])
        );
    end

    // Statistics: a flush counts as a bubble even when hold is also set; both saturate.
    always_comb begin
        bubble_cnt_d = bubble_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        if (bus.flush_e) begin
            if (bubble_cnt_q != '1) begin
                bubble_cnt_d = bubble_cnt_q + CNT_W'(1);
            end else begin
                bubble_cnt_d = bubble_cnt_q;
            end
        end else if (bus.hold_e) begin
            if (hold_cnt_q != '1) begin
                hold_cnt_d = hold_cnt_q + CNT_W'(1);
            end else begin
                hold_cnt_d = hold_cnt_q;
            end
        end else begin
            bubble_cnt_d = bubble_cnt_q;
            hold_cnt_d   = hold_cnt_q;
        end
    end

    // Statistics registers; only reset clears them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt_q <= '0;
            hold_cnt_q   <= '0;
        end else begin
            bubble_cnt_q <= bubble_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

    assign bus.valid_e     = valid_s;
    assign bus.ir_e        = ir_s;
    assign bus.pc4_e       = pc4_s;
    assign bus.rs_e        = rs_s;
    assign bus.rt_e        = rt_s;
    assign bus.ext_e       = ext_s;
    assign bus.wb_data_e   = wb_data_s;
    assign bus.a3_e        = a3_s;
    assign bus.reg_write_e = reg_write_s;
    assign bus.mem_write_e = mem_write_s;
    assign bus.bubble_cnt  = bubble_cnt_q;
    assign bus.hold_cnt    = hold_cnt_q;

endmodule

// File: tb/tb_id_ex_pipe_reg.sv
// Directed bench: a 2-lane instance with 4-bit counters and a 1-lane instance
// without cmov logic and 16-bit counters, sharing clock, reset, hold and flush.
module tb_id_ex_pipe_reg;
    import pipe_pkg::*;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_ex_pipe_reg_if #(.LANES(2), .DW(32), .AW(5), .CNT_W(4))  bus ();
    id_ex_pipe_reg_if #(.LANES(1), .DW(32), .AW(5), .CNT_W(16)) bus_nc ();

    assign bus_nc.hold_e  = bus.hold_e;
    assign bus_nc.flush_e = bus.flush_e;

    id_ex_pipe_reg #(.LANES(2), .DW(32), .AW(5), .CMOV_EN(1'b1), .CNT_W(4)) dut (
        .clk(clk), .reset(reset), .bus(bus));
    id_ex_pipe_reg #(.LANES(1), .DW(32), .AW(5), .CMOV_EN(1'b0), .CNT_W(16)) dut_nc (
        .clk(clk), .reset(reset), .bus(bus_nc));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.hold_e = 1'b0; bus.flush_e = 1'b0;
        bus.ir_d = '0; bus.pc4_d = '0; bus.pc8_d = '0; bus.rs_d = '0; bus.rt_d = '0;
        bus.ext_d = '0; bus.a3_d = '0; bus.reg_write_d = '0; bus.mem_write_d = '0;
        bus.cmov_d = '0; bus.cond_d = '0;
        bus_nc.ir_d = '0; bus_nc.pc4_d = '0; bus_nc.pc8_d = '0; bus_nc.rs_d = '0;
        bus_nc.rt_d = '0; bus_nc.ext_d = '0; bus_nc.a3_d = '0; bus_nc.reg_write_d = '0;
        bus_nc.mem_write_d = '0; bus_nc.cmov_d = '0; bus_nc.cond_d = '0;
    endtask

    // pc4 = pc8-4, rt = ~rs, ext = zero-extended ir[15:0].
    task automatic drive_lane(input int l, input logic [31:0] ir, input logic [31:0] pc8,
                              input logic [31:0] rs, input logic [4:0] a3, input logic rw,
                              input logic mw, input logic cm, input logic cd);
        bus.ir_d[l*32 +: 32]  = ir;
        bus.pc4_d[l*32 +: 32] = pc8 - 32'd4;
        bus.pc8_d[l*32 +: 32] = pc8;
        bus.rs_d[l*32 +: 32]  = rs;
        bus.rt_d[l*32 +: 32]  = rs ^ 32'hFFFF_FFFF;
        bus.ext_d[l*32 +: 32] = {16'h0000, ir[15:0]};
        bus.a3_d[l*5 +: 5]    = a3;
        bus.reg_write_d[l]    = rw;
        bus.mem_write_d[l]    = mw;
        bus.cmov_d[l]         = cm;
        bus.cond_d[l]         = cd;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        clear_inputs();
        drive_lane(0, 32'h0109_5020, 32'h3008, 32'h1111, 5'd10, 1'b1, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        total++; if (bus.valid_e !== 2'b00) begin bad++; $display("FAIL rst_valid: got %b want 00", bus.valid_e); end
        total++; if (bus.ir_e !== 64'h0) begin bad++; $display("FAIL rst_ir: got %h want 0", bus.ir_e); end
        total++; if (bus.wb_data_e !== 64'h0) begin bad++; $display("FAIL rst_wb: got %h want 0", bus.wb_data_e); end
        total++; if ({bus.reg_write_e, bus.mem_write_e, bus.a3_e} !== 14'h0) begin bad++; $display("FAIL rst_ctl: got %h want 0", {bus.reg_write_e, bus.mem_write_e, bus.a3_e}); end
        total++; if ({bus.bubble_cnt, bus.hold_cnt} !== 8'h00) begin bad++; $display("FAIL rst_cnt: got %h want 00", {bus.bubble_cnt, bus.hold_cnt}); end
        total++; if (bus_nc.valid_e !== 1'b0) begin bad++; $display("FAIL rst_nc_valid: got %b want 0", bus_nc.valid_e); end
        reset = 1'b0;
    endtask

    task automatic test_load();
        clear_inputs();
        drive_lane(0, 32'h0109_5020, 32'h3008, 32'h1111, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_lane(1, 32'hAC0B_0008, 32'h300C, 32'h2222, 5'd11, 1'b0, 1'b1, 1'b0, 1'b0);
        #1;
        total++; if (bus.valid_e !== 2'b00) begin bad++; $display("FAIL load_no_comb: got %b want 00", bus.valid_e); end
        tick();
        total++; if (bus.valid_e !== 2'b11) begin bad++; $display("FAIL load_valid: got %b want 11", bus.valid_e); end
        total++; if (bus.ir_e[31:0] !== 32'h0109_5020) begin bad++; $display("FAIL load_ir: got %h want 01095020", bus.ir_e[31:0]); end
        total++; if (bus.wb_data_e[31:0] !== 32'h3008) begin bad++; $display("FAIL load_wb0: got %h want 3008", bus.wb_data_e[31:0]); end
        total++; if (bus.a3_e[4:0] !== 5'd10) begin bad++; $display("FAIL load_a3: got %0d want 10", bus.a3_e[4:0]); end
        total++; if (bus.pc4_e[31:0] !== 32'h3004) begin bad++; $display("FAIL load_pc4: got %h want 3004", bus.pc4_e[31:0]); end
        total++; if (bus.rt_e[31:0] !== 32'hFFFF_EEEE) begin bad++; $display("FAIL load_rt: got %h want ffffeeee", bus.rt_e[31:0]); end
        total++; if (bus.rs_e[63:32] !== 32'h2222) begin bad++; $display("FAIL load_rs1: got %h want 2222", bus.rs_e[63:32]); end
        total++; if (bus.ext_e !== 64'h0000_0008_0000_5020) begin bad++; $display("FAIL load_ext: got %h want 0000000800005020", bus.ext_e); end
        total++; if ({bus.reg_write_e, bus.mem_write_e} !== 4'b0110) begin bad++; $display("FAIL load_rw_mw: got %b want 0110", {bus.reg_write_e, bus.mem_write_e}); end
        total++; if (bus.wb_data_e[63:32] !== 32'h300C) begin bad++; $display("FAIL load_wb1: got %h want 300c", bus.wb_data_e[63:32]); end
    endtask

    task automatic test_hold();
        bus.hold_e = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive_lane(0, 32'h1234_5678 + 32'(i), 32'h9000, 32'h99, 5'd20, 1'b0, 1'b1, 1'b0, 1'b0);
            tick();
            total++; if (bus.ir_e[31:0] !== 32'h0109_5020 || bus.wb_data_e[31:0] !== 32'h3008 || bus.valid_e !== 2'b11)
                begin bad++; $display("FAIL hold_frozen%0d: got ir=%h wb=%h v=%b want 01095020 3008 11", i, bus.ir_e[31:0], bus.wb_data_e[31:0], bus.valid_e); end
        end
        total++; if (bus.hold_cnt !== 4'd3) begin bad++; $display("FAIL hold_cnt: got %0d want 3", bus.hold_cnt); end
        total++; if (bus_nc.hold_cnt !== 16'd3) begin bad++; $display("FAIL hold_cnt_nc: got %0d want 3", bus_nc.hold_cnt); end
        bus.flush_e = 1'b1;
        tick();
        total++; if (bus.valid_e !== 2'b00 || bus.ir_e !== 64'h0 || bus.wb_data_e !== 64'h0)
            begin bad++; $display("FAIL flush_payload: got v=%b ir=%h wb=%h want 0", bus.valid_e, bus.ir_e, bus.wb_data_e); end
        total++; if ({bus.reg_write_e, bus.mem_write_e, bus.a3_e} !== 14'h0) begin bad++; $display("FAIL flush_ctl: got %h want 0", {bus.reg_write_e, bus.mem_write_e, bus.a3_e}); end
        total++; if (bus.bubble_cnt !== 4'd1 || bus.hold_cnt !== 4'd3) begin bad++; $display("FAIL flush_hold_cnt: got b=%0d h=%0d want 1 3", bus.bubble_cnt, bus.hold_cnt); end
    endtask

    task automatic test_cmov();
        logic [31:0] movz_w;
        movz_w = 32'h0085_400A;
        clear_inputs();
        drive_lane(0, movz_w, 32'h4008, 32'hDEAD_BEEF, 5'd8, 1'b1, 1'b0, is_cmov(movz_w), 1'b1);
        tick();
        total++; if (bus.wb_data_e[31:0] !== 32'hDEAD_BEEF) begin bad++; $display("FAIL cmov_take_wb: got %h want deadbeef", bus.wb_data_e[31:0]); end
        total++; if (bus.reg_write_e[0] !== 1'b1 || bus.a3_e[4:0] !== 5'd8) begin bad++; $display("FAIL cmov_take_wr: got rw=%b a3=%0d want 1 8", bus.reg_write_e[0], bus.a3_e[4:0]); end
        bus.cond_d[0] = 1'b0;
        tick();
        total++; if (bus.reg_write_e[0] !== 1'b0 || bus.a3_e[4:0] !== 5'd0) begin bad++; $display("FAIL cmov_kill: got rw=%b a3=%0d want 0 0", bus.reg_write_e[0], bus.a3_e[4:0]); end
        total++; if (bus.valid_e[0] !== 1'b1 || bus.ir_e[31:0] !== movz_w) begin bad++; $display("FAIL cmov_kill_valid: got v=%b ir=%h want 1 0085400a", bus.valid_e[0], bus.ir_e[31:0]); end
    endtask

    task automatic test_lanes();
        clear_inputs();
        drive_lane(0, 32'h0109_5020, 32'h5008, 32'h55, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_lane(1, 32'h0085_400B, 32'h500C, 32'h66, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        tick();
        total++; if (bus.reg_write_e !== 2'b01 || bus.a3_e !== 10'h003) begin bad++; $display("FAIL lanes_kill1: got rw=%b a3=%h want 01 003", bus.reg_write_e, bus.a3_e); end
        total++; if (bus.valid_e !== 2'b11 || bus.wb_data_e[31:0] !== 32'h5008) begin bad++; $display("FAIL lanes_l0: got v=%b wb=%h want 11 5008", bus.valid_e, bus.wb_data_e[31:0]); end
        drive_lane(0, 32'h0085_400A, 32'h6008, 32'h55, 5'd3, 1'b1, 1'b0, 1'b1, 1'b0);
        drive_lane(1, 32'h0085_400B, 32'h600C, 32'h77, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        tick();
        total++; if (bus.reg_write_e !== 2'b10 || bus.a3_e !== 10'h080) begin bad++; $display("FAIL lanes_kill0: got rw=%b a3=%h want 10 080", bus.reg_write_e, bus.a3_e); end
        total++; if (bus.wb_data_e[63:32] !== 32'h77) begin bad++; $display("FAIL lanes_wb1: got %h want 77", bus.wb_data_e[63:32]); end
        drive_lane(0, 32'h0000_0020, 32'h7008, 32'h1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        drive_lane(1, 32'h0000_F820, 32'h700C, 32'h2, 5'd31, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        total++; if (bus.reg_write_e !== 2'b11 || bus.a3_e !== 10'h3E0) begin bad++; $display("FAIL r0_pass: got rw=%b a3=%h want 11 3e0", bus.reg_write_e, bus.a3_e); end
    endtask

    task automatic test_cmov_disabled();
        clear_inputs();
        bus_nc.ir_d = 32'h0085_400A; bus_nc.pc8_d = 32'h6008; bus_nc.rs_d = 32'h123;
        bus_nc.a3_d = 5'd7; bus_nc.reg_write_d = 1'b1; bus_nc.cmov_d = 1'b1; bus_nc.cond_d = 1'b0;
        tick();
        total++; if (bus_nc.reg_write_e !== 1'b1 || bus_nc.a3_e !== 5'd7) begin bad++; $display("FAIL nocmov_wr: got rw=%b a3=%0d want 1 7", bus_nc.reg_write_e, bus_nc.a3_e); end
        total++; if (bus_nc.wb_data_e !== 32'h6008 || bus_nc.valid_e !== 1'b1) begin bad++; $display("FAIL nocmov_wb: got wb=%h v=%b want 6008 1", bus_nc.wb_data_e, bus_nc.valid_e); end
        bus_nc.cond_d = 1'b1;
        tick();
        total++; if (bus_nc.wb_data_e !== 32'h6008) begin bad++; $display("FAIL nocmov_take_wb: got %h want 6008", bus_nc.wb_data_e); end
    endtask

    task automatic test_saturate();
        clear_inputs();
        bus.flush_e = 1'b1;
        repeat (14) tick();
        total++; if (bus.bubble_cnt !== 4'hF) begin bad++; $display("FAIL sat_bubble_reach: got %h want f", bus.bubble_cnt); end
        repeat (6) tick();
        total++; if (bus.bubble_cnt !== 4'hF) begin bad++; $display("FAIL sat_bubble_stick: got %h want f", bus.bubble_cnt); end
        total++; if (bus_nc.bubble_cnt !== 16'd21) begin bad++; $display("FAIL sat_bubble_nc: got %0d want 21", bus_nc.bubble_cnt); end
        total++; if (bus.hold_cnt !== 4'd3 || bus.valid_e !== 2'b00) begin bad++; $display("FAIL sat_flush_side: got h=%0d v=%b want 3 00", bus.hold_cnt, bus.valid_e); end
        bus.flush_e = 1'b0;
    endtask

    task automatic test_hold_sat();
        clear_inputs();
        drive_lane(0, 32'hCAFE_0001, 32'h7008, 32'h3, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        bus.hold_e = 1'b1;
        for (int i = 0; i < 14; i++) begin
            drive_lane(0, 32'hBEEF_0000 + 32'(i), 32'h8008, 32'h4, 5'd6, 1'b0, 1'b0, 1'b0, 1'b0);
            tick();
        end
        total++; if (bus.ir_e[31:0] !== 32'hCAFE_0001 || bus.a3_e[4:0] !== 5'd5) begin bad++; $display("FAIL hsat_frozen: got ir=%h a3=%0d want cafe0001 5", bus.ir_e[31:0], bus.a3_e[4:0]); end
        total++; if (bus.hold_cnt !== 4'hF || bus.bubble_cnt !== 4'hF) begin bad++; $display("FAIL hsat_cnt: got h=%h b=%h want f f", bus.hold_cnt, bus.bubble_cnt); end
        total++; if (bus_nc.hold_cnt !== 16'd17) begin bad++; $display("FAIL hsat_cnt_nc: got %0d want 17", bus_nc.hold_cnt); end
        bus.hold_e = 1'b0;
    endtask

    task automatic test_async_reset();
        clear_inputs();
        drive_lane(0, 32'h0109_5020, 32'h3008, 32'h1111, 5'd10, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        bus.hold_e = 1'b1;
        tick();
        #2;
        reset = 1'b1;
        #1;
        total++; if (bus.valid_e !== 2'b00 || bus.ir_e !== 64'h0 || bus.wb_data_e !== 64'h0) begin bad++; $display("FAIL areset_payload: got v=%b ir=%h wb=%h want 0", bus.valid_e, bus.ir_e, bus.wb_data_e); end
        total++; if (bus.reg_write_e !== 2'b00 || bus.a3_e !== 10'h0) begin bad++; $display("FAIL areset_ctl: got rw=%b a3=%h want 0", bus.reg_write_e, bus.a3_e); end
        total++; if (bus.hold_cnt !== 4'h0 || bus.bubble_cnt !== 4'h0 || bus_nc.hold_cnt !== 16'h0 || bus_nc.bubble_cnt !== 16'h0)
            begin bad++; $display("FAIL areset_cnt: got h=%h b=%h hn=%h bn=%h want 0", bus.hold_cnt, bus.bubble_cnt, bus_nc.hold_cnt, bus_nc.bubble_cnt); end
        bus.hold_e = 1'b0;
        tick();
        total++; if (bus.valid_e !== 2'b00) begin bad++; $display("FAIL areset_held: got %b want 00", bus.valid_e); end
        reset = 1'b0;
        tick();
        total++; if (bus.valid_e !== 2'b11 || bus.ir_e[31:0] !== 32'h0109_5020) begin bad++; $display("FAIL areset_reload: got v=%b ir=%h want 11 01095020", bus.valid_e, bus.ir_e[31:0]); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_hold();
        test_cmov();
        test_lanes();
        test_cmov_disabled();
        test_saturate();
        test_hold_sat();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
